// File: rtl/maj55_voter_if.sv
// Bundle of the 55 voter inputs and the registered majority output.
// The driver side uses the master modport and the voter uses the slave modport.
interface maj55_voter_if;
  logic x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,  x10;
  logic x11, x12, x13, x14, x15, x16, x17, x18, x19, x20, x21;
  logic x22, x23, x24, x25, x26, x27, x28, x29, x30, x31, x32;
  logic x33, x34, x35, x36, x37, x38, x39, x40, x41, x42, x43;
  logic x44, x45, x46, x47, x48, x49, x50, x51, x52, x53, x54;
  logic y0;

  modport master (
    output x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,  x10,
    output x11, x12, x13, x14, x15, x16, x17, x18, x19, x20, x21,
    output x22, x23, x24, x25, x26, x27, x28, x29, x30, x31, x32,
    output x33, x34, x35, x36, x37, x38, x39, x40, x41, x42, x43,
    output x44, x45, x46, x47, x48, x49, x50, x51, x52, x53, x54,
    input  y0
  );

  modport slave (
    input  x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,  x10,
    input  x11, x12, x13, x14, x15, x16, x17, x18, x19, x20, x21,
    input  x22, x23, x24, x25, x26, x27, x28, x29, x30, x31, x32,
    input  x33, x34, x35, x36, x37, x38, x39, x40, x41, x42, x43,
    input  x44, x45, x46, x47, x48, x49, x50, x51, x52, x53, x54,
    output y0
  );
endinterface

// File: rtl/maj55_voter.sv
// Registered 55-input majority voter: y0 goes high one cycle after at least
// 28 of the 55 inputs were 1. The population count is summed combinationally
// and only the single-bit result is stored, so there is no pipeline beyond
// the output flop.
module maj55_voter (
  input  logic         clk,
  input  logic         rst,
  maj55_voter_if.slave bus
);

  localparam int unsigned NumInputs = 55;
  localparam logic [5:0]  Threshold = 6'd28;

  logic [54:0] xVec;
  logic [5:0]  hw;
  logic        y0_d;
  logic        y0_q;

  // x0 is the LSB of the logical voter vector.
  assign xVec = {bus.x54, bus.x53, bus.x52, bus.x51, bus.x50, bus.x49, bus.x48, bus.x47, bus.x46, bus.x45, bus.x44,
                 bus.x43, bus.x42, bus.x41, bus.x40, bus.x39, bus.x38, bus.x37, bus.x36, bus.x35, bus.x34, bus.x33,
                 bus.x32, bus.x31, bus.x30, bus.x29, bus.x28, bus.x27, bus.x26, bus.x25, bus.x24, bus.x23, bus.x22,
                 bus.x21, bus.x20, bus.x19, bus.x18, bus.x17, bus.x16, bus.x15, bus.x14, bus.x13, bus.x12, bus.x11,
                 bus.x10, bus.x9,  bus.x8,  bus.x7,  bus.x6,  bus.x5,  bus.x4,  bus.x3,  bus.x2,  bus.x1,  bus.x0};

  // Count the ones (max 55, so 6 bits never overflow) and compare against 28.
  always_comb begin
    hw = 6'd0;
    for (int i = 0; i < NumInputs; i++) begin
      hw = hw + 6'(xVec[i]);
    end
    y0_d = (hw >= Threshold);
  end

  // Output flop: synchronous reset wins over the freshly computed majority.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q <= 1'b0;
    end else begin
      y0_q <= y0_d;
    end
  end

  assign bus.y0 = y0_q;

endmodule

// File: tb/tb_maj55_voter.sv
// Scoreboard bench for maj55_voter: the driver pushes the expected y0 for
// every vector it applies, and a separate monitor pops and compares one entry
// per clock after the edge that should have registered it.
module tb_maj55_voter;

  logic        clk;
  logic        rstSig;
  logic [54:0] xVec;
  bit          expQ[$];
  int          total;
  int          bad;
  int          cycleNo;

  maj55_voter_if bus ();

  assign {bus.x54, bus.x53, bus.x52, bus.x51, bus.x50, bus.x49, bus.x48, bus.x47, bus.x46, bus.x45, bus.x44,
          bus.x43, bus.x42, bus.x41, bus.x40, bus.x39, bus.x38, bus.x37, bus.x36, bus.x35, bus.x34, bus.x33,
          bus.x32, bus.x31, bus.x30, bus.x29, bus.x28, bus.x27, bus.x26, bus.x25, bus.x24, bus.x23, bus.x22,
          bus.x21, bus.x20, bus.x19, bus.x18, bus.x17, bus.x16, bus.x15, bus.x14, bus.x13, bus.x12, bus.x11,
          bus.x10, bus.x9,  bus.x8,  bus.x7,  bus.x6,  bus.x5,  bus.x4,  bus.x3,  bus.x2,  bus.x1,  bus.x0} = xVec;

  maj55_voter dut (
    .clk (clk),
    .rst (rstSig),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector at the falling edge and record what y0 must be after the next rising edge.
  task automatic applyStimulus(input logic [54:0] v, input logic r, input bit want);
    @(negedge clk);
    xVec   = v;
    rstSig = r;
    expQ.push_back(want);
  endtask

  // Reference majority used for the random portions.
  function automatic bit refMaj(input logic [54:0] v);
    return ($countones(v) >= 28);
  endfunction

  // Random vector with exactly hw ones at random positions.
  function automatic logic [54:0] makeBiased(input int hw);
    logic [54:0] v;
    v = '0;
    while ($countones(v) < hw) v[$urandom_range(0, 54)] = 1'b1;
    return v;
  endfunction

  function automatic logic [54:0] makeRandom();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[54:0];
  endfunction

  task automatic checkOutput(input bit want);
    total++;
    if (bus.y0 !== want) begin
      bad++;
      $display("[TB] FAIL y0 cycle=%0d got=%b want=%b", cycleNo, bus.y0, want);
    end
  endtask

  // Monitor: one expected entry is consumed per rising edge once the driver has started.
  initial begin
    cycleNo = 0;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed vectors with hand-computed results, then random and biased traffic.
  initial begin
    logic [54:0] allOnes;
    logic [54:0] low27;
    logic [54:0] low28;
    logic [54:0] high27;
    logic [54:0] high28;
    logic [54:0] v;
    total   = 0;
    bad     = 0;
    xVec    = '0;
    rstSig  = 1'b1;
    allOnes = {55{1'b1}};
    low27   = allOnes >> 28;
    low28   = allOnes >> 27;
    high27  = allOnes << 28;
    high28  = allOnes << 27;

    applyStimulus(allOnes, 1'b1, 1'b0);
    applyStimulus(allOnes, 1'b1, 1'b0);
    applyStimulus(allOnes, 1'b0, 1'b1);

    applyStimulus(low27, 1'b0, 1'b0);
    applyStimulus(low28, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus(allOnes, 1'b0, 1'b1);
    applyStimulus(high27, 1'b0, 1'b0);
    applyStimulus(high28, 1'b0, 1'b1);

    // Alternating hw=28 / hw=27 with no gaps, using several bit placements.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(high28, 1'b0, 1'b1);
      applyStimulus(low27, 1'b0, 1'b0);
      applyStimulus(low28, 1'b0, 1'b1);
      applyStimulus(high27, 1'b0, 1'b0);
    end

    // Random traffic with a one-cycle reset pulse every 97 vectors.
    for (int i = 0; i < 3000; i++) begin
      v = makeRandom();
      if (i % 97 == 50) applyStimulus(v, 1'b1, 1'b0);
      else              applyStimulus(v, 1'b0, refMaj(v));
    end

    // Vectors hugging the threshold, hw in 25..30.
    for (int i = 0; i < 1200; i++) begin
      v = makeBiased(25 + (i % 6));
      applyStimulus(v, 1'b0, refMaj(v));
    end

    @(negedge clk);
    rstSig = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain leftover=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
